// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types and constants for the AES decryption datapath.
package aes_dec_pkg;
   typedef logic [127:0] state_t;
   typedef logic [31:0]  col_t;
   typedef enum logic {IDLE, SEND} fsm_t;
   localparam int NR_AES256 = 14;
endpackage

// File: rtl/ark_round_ctr.sv
// ark_round_ctr: counts accepted rounds and flags a final-round marker that arrives out of sequence.
module ark_round_ctr
   import aes_dec_pkg::*;
#(
   parameter int NR = NR_AES256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_acc,
   input  logic i_last,
   output logic o_err
);
   localparam int CW = NR > 1 ? $clog2(NR) : 1;
   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic          w_top;
   assign w_top = r_cnt == CW'(NR - 1);
   assign o_err = r_err;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (i_acc) begin
         r_err <= r_err | (i_last != w_top);
         r_cnt <= (i_last || w_top) ? '0 : r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/ark_col_serializer.sv
// ark_col_serializer: AddRoundKey on a 128-bit state, then emits it one column per handshake.
// Round-sequence checking is compiled in with `define ARK_ROUND_CHECK_EN.
module ark_col_serializer
   import aes_dec_pkg::*;
#(
   parameter int NR = NR_AES256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  state_t      in_state,
   input  state_t      in_key,
   input  logic        in_last,
   output logic        col_valid,
   input  logic        col_ready,
   output col_t        col_data,
   output logic [1:0]  col_idx,
   output logic        col_last,
   output logic        col_bypass,
   output logic        rnd_err
);
   fsm_t       r_state;
   logic [1:0] r_idx;
   state_t     r_blk;
   logic       r_bypass;
   logic       w_acc;
   logic       w_hs;
   assign col_valid  = r_state == SEND;
   assign w_hs       = col_valid && col_ready;
   // A new block may land on the same edge that retires column 3.
   assign in_ready   = r_state == IDLE || (r_idx == 2'd3 && col_ready);
   assign w_acc      = in_valid && in_ready;
   assign col_idx    = r_idx;
   assign col_last   = col_valid && r_idx == 2'd3;
   assign col_bypass = r_bypass;
   assign col_data   = r_idx == 2'd0 ? r_blk[127:96] :
                       r_idx == 2'd1 ? r_blk[95:64]  :
                       r_idx == 2'd2 ? r_blk[63:32]  : r_blk[31:0];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_idx    <= 2'd0;
         r_blk    <= '0;
         r_bypass <= 1'b0;
      end else if (w_acc) begin
         r_state  <= SEND;
         r_idx    <= 2'd0;
         r_blk    <= in_state ^ in_key;
         r_bypass <= in_last;
      end else if (w_hs) begin
         r_idx    <= r_idx + 2'd1;
         r_state  <= r_idx == 2'd3 ? IDLE : SEND;
      end
   end
`ifdef ARK_ROUND_CHECK_EN
   ark_round_ctr #(.NR(NR)) u_rnd (
      .clk    (clk),
      .rst    (rst),
      .i_acc  (w_acc),
      .i_last (in_last),
      .o_err  (rnd_err)
   );
`else
   assign rnd_err = 1'b0 && (NR > 0);
`endif
endmodule
